// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request/response and data-memory bus of the MEM-stage load/store unit.
interface mem_stage_lsu_if #(
    parameter int WORD_AW = 7
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [1:0]         req_size;
    logic               req_signed;
    logic [WORD_AW+1:0] req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               misalign;
    logic [WORD_AW-1:0] dm_addr;
    logic               dm_rd;
    logic               dm_wr;
    logic [31:0]        dm_wdata;
    logic [31:0]        dm_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_rdata, misalign, dm_addr, dm_rd, dm_wr, dm_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, misalign, dm_addr, dm_rd, dm_wr, dm_wdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MIPS MEM-stage load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_EXC_EN to flag and suppress misaligned/illegal requests instead of aligning them.
module mem_stage_lsu #(
    parameter int WORD_AW = 7
) (
    input logic            clk,
    input logic            rst_n,
    mem_stage_lsu_if.slave bus
);
    typedef enum logic {IDLE, MERGE} state_t;
    state_t             state, state_nx;
    logic [31:0]        old_q;
    logic [WORD_AW+1:0] addr_q;
    logic               half_q;
    logic [15:0]        wdata_q;
    logic               resp_valid_q, misalign_q;
    logic [31:0]        resp_rdata_q;
    logic               acc, bad, sub, ld, rmw;
    logic [1:0]         size_eff, lo;
    logic [4:0]         sh, sh_q;
    logic [15:0]        lane;
    logic [31:0]        ext, mask, merged;

`ifdef LSU_MISALIGN_EXC_EN
    assign bad = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif
    // Without trapping, reserved size acts as word and low address bits are aligned down
    assign size_eff = bus.req_size == 2'b11 ? 2'b10 : bus.req_size;
    assign lo = size_eff == 2'b00 ? bus.req_addr[1:0] : size_eff == 2'b01 ? {bus.req_addr[1], 1'b0} : 2'b00;
    assign sub = !size_eff[1];
    assign acc = bus.req_valid && state == IDLE;
    assign ld = acc && !bad && !bus.req_we;
    assign rmw = acc && !bad && bus.req_we && sub;
    assign sh = {lo, 3'b000};
    assign lane = 16'(bus.dm_rdata >> sh);
    assign ext = size_eff == 2'b00 ? {{24{bus.req_signed && lane[7]}}, lane[7:0]} :
                 size_eff == 2'b01 ? {{16{bus.req_signed && lane[15]}}, lane} : bus.dm_rdata;
    assign sh_q = {addr_q[1:0], 3'b000};
    assign mask = (half_q ? 32'h0000_FFFF : 32'h0000_00FF) << sh_q;
    assign merged = (old_q & ~mask) | (({16'h0000, wdata_q} << sh_q) & mask);
    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.misalign = misalign_q;

    always_comb begin
        state_nx = state;
        bus.dm_rd = 1'b0;
        bus.dm_wr = 1'b0;
        bus.dm_addr = bus.req_addr[WORD_AW+1:2];
        bus.dm_wdata = bus.req_wdata;
        if (state == MERGE) begin
            state_nx = IDLE;
            bus.dm_wr = 1'b1;
            bus.dm_addr = addr_q[WORD_AW+1:2];
            bus.dm_wdata = merged;
        end else if (acc && !bad && rst_n) begin
            bus.dm_rd = !bus.req_we || sub;
            bus.dm_wr = bus.req_we && !sub;
            state_nx = rmw ? MERGE : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            old_q <= '0;
            addr_q <= '0;
            half_q <= 1'b0;
            wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_nx;
            resp_valid_q <= ld;
            misalign_q <= acc && bad;
            if (ld)
                resp_rdata_q <= ext;
            if (rmw) begin
                old_q <= bus.dm_rdata;
                addr_q <= {bus.req_addr[WORD_AW+1:2], lo};
                half_q <= size_eff[0];
                wdata_q <= bus.req_wdata[15:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random checks of mem_stage_lsu against a byte-array memory model.
module tb_mem_stage_lsu;
`ifdef LSU_MISALIGN_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fill = 1'b0;
    logic [31:0] seed;
    logic [31:0] mem [128];
    logic [7:0] refb [512];
    int checks = 0;
    int errors = 0;
    logic [31:0] got;

    mem_stage_lsu_if #(.WORD_AW(7)) bus();
    mem_stage_lsu #(.WORD_AW(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.dm_rdata = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= (32'(i) * 32'h9E37_79B9) ^ seed;
        end else if (bus.dm_wr) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
        end
    end

    function automatic logic [31:0] refword(input int w);
        return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_resp_valid", bus.resp_valid, 0);
        check("idle_misalign", bus.misalign, 0);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [8:0] ad,
                         input logic [31:0] wd, output logic [31:0] res);
        int n;
        logic bad, sub;
        logic [8:0] a;
        logic [31:0] v;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        bad = EXC && (sz == 2'd3 || (int'(ad) % n) != 0);
        a = ad - 9'(int'(ad) % n);
        sub = n < 4;
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(refb[a + 9'(i)]) << (8 * i));
        if (sg && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = sz;
        bus.req_signed = sg;
        bus.req_addr = ad;
        bus.req_wdata = wd;
        #1;
        check("ready", bus.req_ready, 1);
        check("dm_rd", bus.dm_rd, !bad && (!we || sub));
        check("dm_wr", bus.dm_wr, !bad && we && !sub);
        if (!bad)
            check("dm_addr", 32'(bus.dm_addr), 32'(a >> 2));
        if (!bad && we && !sub)
            check("dm_wdata", bus.dm_wdata, wd);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        res = bus.resp_rdata;
        check("resp_valid", bus.resp_valid, !bad && !we);
        if (!bad && !we)
            check("resp_rdata", bus.resp_rdata, v);
        check("misalign", bus.misalign, bad);
        if (!bad && we)
            for (int i = 0; i < n; i++)
                refb[a + 9'(i)] = wd[8*i +: 8];
        if (!bad && we && sub) begin
            check("merge_ready", bus.req_ready, 0);
            check("merge_rd", bus.dm_rd, 0);
            check("merge_wr", bus.dm_wr, 1);
            check("merge_addr", 32'(bus.dm_addr), 32'(a >> 2));
            check("merge_wdata", bus.dm_wdata, refword(int'(a >> 2)));
            @(posedge clk);
            #1;
            check("after_merge_ready", bus.req_ready, 1);
        end
        check("mem_word", mem[a >> 2], refword(int'(a >> 2)));
    endtask

    initial begin
        seed = $urandom;
        for (int w = 0; w < 128; w++)
            for (int b = 0; b < 4; b++)
                refb[4*w+b] = 8'(((32'(w) * 32'h9E37_79B9) ^ seed) >> (8 * b));
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        fill = 1'b1;
        @(posedge clk);
        #1;
        fill = 1'b0;
        check("rst_dm_rd", bus.dm_rd, 0);
        check("rst_dm_wr", bus.dm_wr, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_misalign", bus.misalign, 0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEAD_BEEF, got);
        issue(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, got);
        check("plan_word_load", got, 32'hDEAD_BEEF);
        issue(1'b1, 2'd0, 1'b0, 9'h011, 32'h0000_005A, got);
        check("plan_byte_merge", mem[4], 32'hDEAD_5AEF);
        issue(1'b1, 2'd2, 1'b0, 9'h010, 32'h80FF_0000, got);
        issue(1'b0, 2'd0, 1'b1, 9'h013, 32'h0, got);
        check("plan_sbyte", got, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b0, 9'h013, 32'h0, got);
        check("plan_ubyte", got, 32'h0000_0080);
        issue(1'b1, 2'd2, 1'b0, 9'h010, 32'h8001_1234, got);
        issue(1'b0, 2'd1, 1'b1, 9'h012, 32'h0, got);
        check("plan_shalf", got, 32'hFFFF_8001);
        issue(1'b0, 2'd1, 1'b0, 9'h012, 32'h0, got);
        check("plan_uhalf", got, 32'h0000_8001);
        issue(1'b1, 2'd2, 1'b0, 9'h020, 32'h1122_3344, got);
        issue(1'b1, 2'd1, 1'b0, 9'h021, 32'h0000_BEEF, got);
        check("plan_misaligned_half", mem[8], EXC ? 32'h1122_3344 : 32'h1122_BEEF);
        idle();

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd1;
        bus.req_addr = 9'h040;
        bus.req_wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("pre_rst_merge_wr", bus.dm_wr, 1);
        rst_n = 1'b0;
        #1;
        check("rst_merge_wr", bus.dm_wr, 0);
        check("rst_merge_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        check("rst_merge_mem", mem[16], refword(16));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.req_ready, 1);
        check("post_rst_resp_valid", bus.resp_valid, 0);
        idle();

        for (int k = 0; k < 200; k++) begin
            logic [8:0] ad;
            ad = ($urandom % 2 == 0) ? 9'($urandom % 512) : 9'($urandom % 32);
            issue(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom, got);
            if ($urandom % 5 == 0)
                idle();
        end
        for (int w = 0; w < 128; w++)
            check("final_mem", mem[w], refword(w));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
